// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller for the dual-port RAM: port A writes, port B reads.
// Owns pointers, occupancy count, status flags and error pulses; rd_data is the RAM q_b passthrough.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_LEVEL   = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  rd_valid_q;
  logic                  wr_err_q;
  logic                  rd_err_q;
  logic                  wr_accept;
  logic                  rd_accept;

  // Accepts depend only on registered flags, so RAM strobes carry no input-to-flag loop.
  assign wr_accept = wr_en & ~full_q;
  assign rd_accept = rd_en & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_nxt;
      full_q     <= (count_nxt == DEPTH_C);
      empty_q    <= (count_nxt == '0);
      af_q       <= (count_nxt >= AF_C);
      rd_valid_q <= rd_accept;
      wr_err_q   <= wr_en & full_q;
      rd_err_q   <= rd_en & empty_q;
    end
  end

  assign ram_we_a    = wr_accept;
  assign ram_addr_a  = wr_ptr;
  assign ram_data_a  = wr_data;
  assign ram_addr_b  = rd_ptr;
  assign ram_data_b  = '0;
  assign ram_we_b    = 1'b0;

  assign rd_data     = ram_q_b;
  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the team's dual-port RAM block: port A is the write path, port B is the read path. It owns the write and read pointers, occupancy count, full/empty/almost-full flags and error pulses. It returns RAM read data to the consumer with a valid strobe. It sits directly upstream of the RAM (driving addr/data/we on both ports) and consumes its port-B registered output.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM instance.
ADDR_WIDTH, 6, RAM address width; depth DEPTH = 2**ADDR_WIDTH.
AF_LEVEL, 60, count threshold at or above which almost_full asserts (1..DEPTH).

Ports:
clk  input  1  single clock, shared with the RAM instance
rst_n  input  1  synchronous active-low reset
wr_en  input  1  producer write request
wr_data  input  DATA_WIDTH  producer write word
rd_en  input  1  consumer read request
rd_data  output  DATA_WIDTH  read word, valid when rd_valid=1
rd_valid  output  1  one-cycle strobe, read data present
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
count  output  ADDR_WIDTH+1  current occupancy
wr_err  output  1  one-cycle pulse: write attempted while full
rd_err  output  1  one-cycle pulse: read attempted while empty
ram_addr_a  output  ADDR_WIDTH  to RAM addr_a (= wr_ptr)
ram_data_a  output  DATA_WIDTH  to RAM data_a (= wr_data)
ram_we_a  output  1  to RAM we_a
ram_addr_b  output  ADDR_WIDTH  to RAM addr_b (= rd_ptr)
ram_data_b  output  DATA_WIDTH  to RAM data_b, tied 0
ram_we_b  output  1  to RAM we_b, tied 0 (port B read-only)
ram_q_b  input  DATA_WIDTH  from RAM q_b

Behaviour:
- Reset (rst_n=0 at posedge clk): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, wr_err=0, rd_err=0. rd_data follows ram_q_b and is don't-care while rd_valid=0.
- wr_accept = wr_en & ~full; rd_accept = rd_en & ~empty. Both are combinational from registered flags.
- RAM drive is combinational from registered state: ram_we_a = wr_accept; ram_addr_a = wr_ptr; ram_data_a = wr_data; ram_addr_b = rd_ptr.
- On wr_accept: the RAM writes at the edge; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- On rd_accept: the RAM captures ram[rd_ptr] into q_b at the edge; rd_ptr <= rd_ptr+1, wrapping modulo DEPTH; rd_valid <= 1 for exactly one cycle.
- Read latency: data appears on rd_data together with rd_valid, one cycle after the accept edge. rd_data = ram_q_b passthrough with no extra register.
- count: +1 on write only, -1 on read only, unchanged on both or neither. Flags are registered from the next-state count.
- Simultaneous rd/wr when empty: the write is accepted, the read is rejected and rd_err pulses. The count ends at 1 and empty falls next cycle.
- Simultaneous rd/wr when full: the read is accepted, the write is rejected and wr_err pulses. The count ends at DEPTH-1.
- Simultaneous rd/wr otherwise: both are accepted and count is unchanged.
- Port A and port B addresses are never equal while both ports are active. Full blocks the write, so a same-address read/write collision cannot occur.
- wr_err <= wr_en & full; rd_err <= rd_en & empty. Each is a one-cycle pulse per offending request cycle.
- Reset mid-operation: any read in flight is discarded (rd_valid=0 after the reset edge). RAM contents are not cleared but become unreachable.
- Unaccepted requests have no side effect on pointers, count or the RAM.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles, then rd_en for 3 cycles -> rd_valid high on the 3 cycles after each accept with rd_data 0x11,0x22,0x33. Count goes 1,2,3, then 2,1,0; empty returns to 1.
- Write 64 words 0x00..0x3F -> full=1 and count=64; almost_full asserts at count 60. A 65th write pulses wr_err=1, and reading all 64 returns 0x00..0x3F in order.
- Fill to 64, then assert wr_en=1 (0xAA) and rd_en=1 in the same cycle -> read returns 0x00, 0xAA is not stored, wr_err=1, count=63.
- From empty, assert rd_en=1 and wr_en=1 (0x5C) in the same cycle -> rd_err=1, no rd_valid, count=1; the next rd_en returns 0x5C.
- Wrap-around: 100 interleaved write/read pairs with count held at 5 -> pointers wrap past 63, and every word matches a reference queue.
- Accept a read, then drop rst_n on the next cycle -> rd_valid=0, count=0, empty=1; a subsequent write/read of 0x7E returns 0x7E.
